median_window_feeder: RTL and testbench

- Upstream stage of the 3x3 median filter.
- Receives an image as a raster-order pixel stream and stores it in a 3-row circular line buffer.
- For every interior pixel, serialises the 3x3 neighbourhood into the median block: DSI held high for 9 consecutive pixels.
- Waits for the median block's DSO, then re-emits the median tagged with its (x,y) coordinates.

---
 rtl/median_window_feeder.sv | 189 ++++++++++++++++++
 tb/tb_median_window_feeder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_feeder.sv
// median_window_feeder: front end of the 3x3 median filter.
// Pixels arrive in raster order and are kept in a three-row circular line
// buffer. Once a row of index >= 2 has been completed, each interior pixel
// of the middle row has its 3x3 neighbourhood streamed to the median block
// as nine back-to-back MED_DSI beats. The returned median is re-emitted
// together with its (x,y) coordinates.
module median_window_feeder #(
    parameter int width = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [width-1:0]           PIX_IN,
    input  logic                       PIX_VALID,
    output logic                       PIX_READY,
    output logic [width-1:0]           MED_DI,
    output logic                       MED_DSI,
    input  logic [width-1:0]           MED_DO,
    input  logic                       MED_DSO,
    output logic [width-1:0]           RES_DO,
    output logic                       RES_VALID,
    output logic [$clog2(IMG_W)-1:0]   RES_X,
    output logic [$clog2(IMG_H)-1:0]   RES_Y,
    output logic                       FRAME_DONE
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int DEPTH = 3 * IMG_W;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        WIN_LOAD = 2'd1,
        WIN_WAIT = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   col_reg;        // write column inside the current row
    logic [CW-1:0]   c_reg;          // centre column of the window in flight
    logic [RW-1:0]   row_cnt_reg;    // row currently being filled
    logic [RW-1:0]   done_row_reg;   // last fully received row (window bottom)
    logic [1:0]      wr_idx_reg;     // line buffer slot being written
    logic [3:0]      load_cnt_reg;   // next window tap to emit, 0..9

    // Three image rows, one write port (pixel input) and one read port
    // (window taps). MED_DI acts as the registered read output.
    logic [width-1:0] line_mem [0:DEPTH-1];

    logic             transfer;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [1:0]       win_base;
    logic [1:0]       rd_row;
    logic [1:0]       kr;
    logic [1:0]       kc;
    logic [3:0]       rd_k;
    logic [CW-1:0]    c_sel;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [1:0] add3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // PIX_READY is only ever high in FILL, so a handshake implies FILL.
    assign transfer = PIX_VALID & PIX_READY;
    assign wr_addr  = AW'(wr_idx_reg) * AW'(IMG_W) + AW'(col_reg);

    // Window tap address. On the FILL->WIN_LOAD edge the write slot has not
    // advanced yet, so the oldest row is the slot after it; afterwards the
    // advanced write slot itself points at the oldest row.
    always_comb begin
        win_base = (state_reg == FILL) ? inc3(wr_idx_reg) : wr_idx_reg;
        c_sel    = (state_reg == FILL) ? CW'(1) : c_reg;
        rd_k     = (state_reg == FILL) ? 4'd0 : load_cnt_reg;
        if (rd_k >= 4'd6) begin
            kr = 2'd2;
            kc = 2'(rd_k - 4'd6);
        end else if (rd_k >= 4'd3) begin
            kr = 2'd1;
            kc = 2'(rd_k - 4'd3);
        end else begin
            kr = 2'd0;
            kc = rd_k[1:0];
        end
        rd_row  = add3(win_base, kr);
        rd_addr = AW'(rd_row) * AW'(IMG_W) + AW'(c_sel) + AW'(kc) - AW'(1);
    end

    // Line buffer write port; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (nRST && transfer) begin
            line_mem[wr_addr] <= PIX_IN;
        end
    end

    // Control FSM with registered outputs and the window read register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg    <= FILL;
            col_reg      <= '0;
            c_reg        <= '0;
            row_cnt_reg  <= '0;
            done_row_reg <= '0;
            wr_idx_reg   <= 2'd0;
            load_cnt_reg <= 4'd0;
            PIX_READY    <= 1'b1;
            MED_DI       <= '0;
            MED_DSI      <= 1'b0;
            RES_DO       <= '0;
            RES_VALID    <= 1'b0;
            RES_X        <= '0;
            RES_Y        <= '0;
            FRAME_DONE   <= 1'b0;
        end else begin
            RES_VALID  <= 1'b0;
            FRAME_DONE <= 1'b0;
            case (state_reg)
                FILL: begin
                    if (transfer) begin
                        if (col_reg == CW'(IMG_W - 1)) begin
                            col_reg      <= '0;
                            row_cnt_reg  <= row_cnt_reg + RW'(1);
                            done_row_reg <= row_cnt_reg;
                            wr_idx_reg   <= inc3(wr_idx_reg);
                            if (row_cnt_reg >= RW'(2)) begin
                                // First tap leaves on this very edge so the
                                // nine beats start right after the last pixel.
                                state_reg    <= WIN_LOAD;
                                c_reg        <= CW'(1);
                                PIX_READY    <= 1'b0;
                                MED_DSI      <= 1'b1;
                                MED_DI       <= line_mem[rd_addr];
                                load_cnt_reg <= 4'd1;
                            end
                        end else begin
                            col_reg <= col_reg + CW'(1);
                        end
                    end
                end
                WIN_LOAD: begin
                    if (load_cnt_reg == 4'd9) begin
                        MED_DSI   <= 1'b0;
                        state_reg <= WIN_WAIT;
                    end else begin
                        MED_DSI      <= 1'b1;
                        MED_DI       <= line_mem[rd_addr];
                        load_cnt_reg <= load_cnt_reg + 4'd1;
                    end
                end
                WIN_WAIT: begin
                    if (MED_DSO) begin
                        RES_DO    <= MED_DO;
                        RES_VALID <= 1'b1;
                        RES_X     <= c_reg;
                        RES_Y     <= done_row_reg - RW'(1);
                        if (c_reg < CW'(IMG_W - 2)) begin
                            // The WIN_LOAD pass starting at tap 0 adds one
                            // idle cycle, keeping MED_DSI clear of RES_VALID.
                            c_reg        <= c_reg + CW'(1);
                            load_cnt_reg <= 4'd0;
                            state_reg    <= WIN_LOAD;
                        end else begin
                            state_reg <= FILL;
                            PIX_READY <= 1'b1;
                            if (done_row_reg == RW'(IMG_H - 1)) begin
                                FRAME_DONE  <= 1'b1;
                                row_cnt_reg <= '0;
                                wr_idx_reg  <= 2'd0;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= FILL;
                    PIX_READY <= 1'b1;
                    MED_DSI   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder on a 4x5 image: a behavioural median block
// answers each window, expected windows/results are queued when pixels are
// sent, and frame scenarios come from a record table.
module tb_median_window_feeder;

    localparam int W = 4;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] med_di;
    logic       med_dsi;
    logic [7:0] med_do;
    logic       med_dso;
    logic [7:0] res_do;
    logic       res_valid;
    logic [1:0] res_x;
    logic [2:0] res_y;
    logic       frame_done;

    logic       model_dso;
    logic [7:0] model_do;
    logic       stray_dso;

    assign med_dso = model_dso | stray_dso;
    assign med_do  = stray_dso ? 8'hA5 : model_do;

    always #5 clk = ~clk;

    median_window_feeder #(.width(8), .IMG_W(W), .IMG_H(H)) dut (
        .CLK(clk), .nRST(nrst), .PIX_IN(pix_in), .PIX_VALID(pix_valid),
        .PIX_READY(pix_ready), .MED_DI(med_di), .MED_DSI(med_dsi),
        .MED_DO(med_do), .MED_DSO(med_dso), .RES_DO(res_do),
        .RES_VALID(res_valid), .RES_X(res_x), .RES_Y(res_y),
        .FRAME_DONE(frame_done)
    );

    typedef struct {
        int val;
        int x;
        int y;
        int fd;
    } res_t;

    typedef struct {
        int valid_mode;   // 0 always, 1 toggling, 2 random
        int pix_mode;     // 0 ramp 4*r+c, 1 random
        int med_lat;      // median block delay after MED_DSI falls
        int exp_results;
        int exp_frames;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          med_lat  = 36;
    int          res_count;
    int          fd_count;
    logic [71:0] win_q[$];
    res_t        res_q[$];
    int          img[H][W];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or protocol violated", name);
    endtask

    function automatic int median9(input logic [71:0] w);
        int a[9];
        int t;
        for (int k = 0; k < 9; k++) a[k] = int'(w[71-8*k -: 8]);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    // Queue the windows and results implied by completing image row r.
    task automatic push_windows(input int r);
        logic [71:0] pk;
        res_t        e;
        for (int c = 1; c <= W - 2; c++) begin
            pk = '0;
            for (int k = 0; k < 9; k++) pk = {pk[63:0], 8'(img[r-2+k/3][c-1+k%3])};
            win_q.push_back(pk);
            e.val = median9(pk);
            e.x   = c;
            e.y   = r - 1;
            e.fd  = (r == H - 1 && c == W - 2) ? 1 : 0;
            res_q.push_back(e);
        end
    endtask

    // Send the first n pixels of a frame; returns on the negedge after the
    // last accepted pixel's edge with PIX_VALID dropped.
    task automatic drive_pixels(input int n, input int vmode, input int pmode);
        int   idx;
        int   budget;
        int   parity;
        int   r;
        int   c;
        int   val;
        logic v;
        idx = 0; budget = 0; parity = 1;
        while (idx < n) begin
            @(negedge clk);
            budget++;
            if (budget > 4000) begin
                note_fail("drive_timeout");
                break;
            end
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(parity) : 1'($urandom_range(0, 1));
            parity ^= 1;
            r = idx / W;
            c = idx % W;
            pix_valid = v;
            if (pix_ready !== 1'b1) begin
                pix_in = 8'hEE;
            end else if (v) begin
                val = (pmode == 0) ? ((4 * r + c) & 255) : int'($urandom_range(0, 255));
                img[r][c] = val;
                pix_in = 8'(val);
                idx++;
                if (c == W - 1 && r >= 2) push_windows(r);
            end else begin
                pix_in = 8'h77;
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    // Behavioural median block: collects MED_DSI beats, checks them against
    // the queued window, then answers with one MED_DSO pulse.
    initial begin
        int          cnt;
        int          dly;
        logic [71:0] got;
        logic [71:0] ex;
        cnt = 0; dly = -1; got = '0;
        model_dso = 1'b0;
        model_do  = 8'd0;
        forever begin
            @(negedge clk);
            model_dso = 1'b0;
            if (nrst !== 1'b1) begin
                cnt = 0;
                dly = -1;
            end else begin
                if (dly == 0) begin
                    model_dso = 1'b1;
                    model_do  = 8'(median9(got));
                    dly = -1;
                end else if (dly > 0) begin
                    dly--;
                end
                if (med_dsi === 1'b1) begin
                    got = {got[63:0], med_di};
                    cnt++;
                end else if (cnt > 0) begin
                    check("dsi_run_length", cnt, 9);
                    if (win_q.size() == 0) begin
                        note_fail("unexpected_window");
                    end else begin
                        ex = win_q.pop_front();
                        n_checks++;
                        if (got !== ex) begin
                            n_fail++;
                            $display("FAIL med_di_window: got %h, expected %h", got, ex);
                        end
                    end
                    $display("window %h", got);
                    dly = med_lat;
                    cnt = 0;
                end
            end
        end
    end

    // Result checker plus output invariants.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1 && res_valid !== 1'b1) note_fail("frame_done_alone");
            if (med_dsi === 1'b1 && (pix_ready === 1'b1 || res_valid === 1'b1)) note_fail("dsi_overlap");
            if (res_valid === 1'b1) begin
                if (res_q.size() == 0) begin
                    note_fail("unexpected_result");
                end else begin
                    e = res_q.pop_front();
                    check("res_do", res_do, e.val);
                    check("res_x", res_x, e.x);
                    check("res_y", res_y, e.y);
                    check("frame_done", frame_done, e.fd);
                    $display("result x=%0d y=%0d val=%0d fd=%0d", res_x, res_y, res_do, frame_done);
                    res_count++;
                    if (frame_done === 1'b1) fd_count++;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t vecs[5];
        int   exp_di[5];
        int   t;

        vecs[0] = '{0, 0, 36, (W-2)*(H-2), 1};
        vecs[1] = '{0, 0, 36, (W-2)*(H-2), 1};
        vecs[2] = '{1, 0, 36, (W-2)*(H-2), 1};
        vecs[3] = '{2, 1, 5,  (W-2)*(H-2), 1};
        vecs[4] = '{1, 1, 0,  (W-2)*(H-2), 1};
        exp_di = '{0, 1, 2, 4, 5};

        res_count = 0;
        fd_count  = 0;
        nrst      = 1'b0;
        pix_valid = 1'b0;
        pix_in    = 8'd0;
        stray_dso = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("rst_pix_ready", pix_ready, 1);
        check("rst_med_dsi", med_dsi, 0);
        check("rst_med_di", med_di, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_do", res_do, 0);
        check("rst_res_x", res_x, 0);
        check("rst_res_y", res_y, 0);
        check("rst_frame_done", frame_done, 0);

        // First window starts right after the 12th pixel; abort it on beat 5
        drive_pixels(3 * W, 0, 0);
        check("win0_pix_ready", pix_ready, 0);
        check("win0_dsi", med_dsi, 1);
        check("win0_di0", med_di, exp_di[0]);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check("win0_dsi_k", med_dsi, 1);
            check("win0_di_k", med_di, exp_di[k]);
            if (k == 4) nrst = 1'b0;
        end
        @(negedge clk);
        check("abort_dsi", med_dsi, 0);
        check("abort_pix_ready", pix_ready, 1);
        win_q.delete();
        res_q.delete();
        nrst = 1'b1;

        // Stray MED_DSO while filling produces nothing
        @(negedge clk);
        stray_dso = 1'b1;
        @(negedge clk);
        stray_dso = 1'b0;
        check("stray_no_result", res_valid, 0);
        @(negedge clk);
        check("stray_no_result_2", res_valid, 0);

        // Frame scenarios
        for (int i = 0; i < 5; i++) begin
            med_lat   = vecs[i].med_lat;
            res_count = 0;
            fd_count  = 0;
            drive_pixels(W * H, vecs[i].valid_mode, vecs[i].pix_mode);
            t = 0;
            while ((win_q.size() != 0 || res_q.size() != 0) && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) note_fail("drain_timeout");
            repeat (2) @(negedge clk);
            check("frame_results", res_count, vecs[i].exp_results);
            check("frame_done_count", fd_count, vecs[i].exp_frames);
            check("frame_pix_ready", pix_ready, 1);
            $display("frame %0d done: %0d results", i, res_count);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
